// File: rtl/sram_init_engine.sv
// SRAM initialisation sequencer: after a re-key, fills every word with LFSR data
// through a req/gnt write port, and aborts permanently on escalation.
`timescale 1ns/1ps
module sram_init_engine #(
  parameter int          DataWidth = 39,
  parameter int          MemDepth  = 1024,
  parameter int          AddrWidth = $clog2(MemDepth),
  parameter logic [63:0] LfsrSeed  = 64'hA5C3_0F1E_9B27_6D48
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 init_req_i,
  input  logic                 key_valid_i,
  input  logic [63:0]          seed_i,
  input  logic                 escalate_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic                 init_busy_o,
  output logic                 init_done_o,
  output logic                 error_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StInit  = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
  localparam logic [1:0] StError = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [63:0]          lfsr_q, lfsr_d;
  logic [63:0]          lfsr_step;
  logic                 last_addr;

  assign lfsr_step = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
  assign last_addr = (addr_q == AddrWidth'(MemDepth - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lfsr_d  = lfsr_q;
    // Escalation overrides every other transition, including the final grant.
    if (escalate_i) begin
      state_d = StError;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (init_req_i && key_valid_i) begin
            state_d = StInit;
            addr_d  = '0;
            lfsr_d  = (seed_i == 64'd0) ? LfsrSeed : seed_i;
          end
        end
        StInit: begin
          if (mem_gnt_i) lfsr_d = lfsr_step;
          if (!key_valid_i) begin
            state_d = StIdle;
            addr_d  = '0;
          end else if (mem_gnt_i) begin
            if (last_addr) state_d = StDone;
            else           addr_d  = addr_q + AddrWidth'(1);
          end
        end
        default: state_d = StError;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      lfsr_q  <= LfsrSeed;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign init_busy_o = (state_q == StInit);
  assign init_done_o = (state_q == StDone);
  assign error_o     = (state_q == StError);
  assign mem_req_o   = init_busy_o & ~escalate_i;
  assign mem_we_o    = mem_req_o;
  // Address/data are only meaningful while writing; keep the bus quiet otherwise.
  assign mem_addr_o  = init_busy_o ? addr_q : '0;
  assign mem_wdata_o = init_busy_o ? lfsr_q[DataWidth-1:0] : '0;

endmodule

// File: tb/tb_sram_init_engine.sv
// Directed bench for sram_init_engine: full pass, stalled pass, seeds, key drop,
// escalation and mid-pass reset.
`timescale 1ns/1ps
module tb_sram_init_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_req, key_valid, escalate, gnt;
  logic [63:0] seed;
  logic        req, we, busy, done, err;
  logic [9:0]  addr;
  logic [38:0] wdata;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [38:0] SeedLow39 = 39'h1E_9B27_6D48;

  sram_init_engine dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .init_req_i  (init_req),
    .key_valid_i (key_valid),
    .seed_i      (seed),
    .escalate_i  (escalate),
    .mem_req_o   (req),
    .mem_gnt_i   (gnt),
    .mem_we_o    (we),
    .mem_addr_o  (addr),
    .mem_wdata_o (wdata),
    .init_busy_o (busy),
    .init_done_o (done),
    .error_o     (err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] lfsr_next(input logic [63:0] x);
    return {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_req = 0; key_valid = 0; escalate = 0; gnt = 0; seed = '0;
    tick(); tick();
    n_cmp++; if ({req, we, busy, done, err} !== 5'b0) begin n_err++;
      $display("FAIL reset_flags: got %b exp 00000", {req, we, busy, done, err}); end
    n_cmp++; if (addr !== 10'd0) begin n_err++; $display("FAIL reset_addr: got %0d exp 0", addr); end
    n_cmp++; if (wdata !== 39'd0) begin n_err++; $display("FAIL reset_wdata: got %h exp 0", wdata); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_full_grant();
    logic [63:0] model;
    model = 64'd1;
    seed = 64'd1; key_valid = 1; gnt = 1; init_req = 1;
    tick();
    init_req = 0;
    n_cmp++; if (wdata !== 39'd1 || req !== 1'b1) begin n_err++;
      $display("FAIL full_first: wdata %h req %b exp 1 1", wdata, req); end
    for (int i = 0; i < 1024; i++) begin
      n_cmp++;
      if (addr !== i[9:0] || wdata !== model[38:0] || req !== 1'b1 || we !== 1'b1) begin
        n_err++;
        if (n_err < 20) $display("FAIL full_write[%0d]: addr %0d wdata %h req %b exp addr %0d wdata %h req 1",
                                 i, addr, wdata, req, i, model[38:0]);
      end
      model = lfsr_next(model);
      tick();
    end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || req !== 1'b0) begin n_err++;
      $display("FAIL full_done: done %b busy %b req %b exp 1 0 0", done, busy, req); end
  endtask

  task automatic test_stall();
    logic [63:0] model;
    int exp_addr, writes, c;
    seed = 64'h0123_4567_89AB_CDEF; model = seed;
    gnt = 0; init_req = 1; key_valid = 1;
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_err++;
      $display("FAIL stall_start: done %b busy %b exp 0 1", done, busy); end
    n_cmp++; if (wdata !== 39'h67_89AB_CDEF) begin n_err++;
      $display("FAIL stall_first_wdata: got %h exp 6789abcdef", wdata); end
    exp_addr = 0; writes = 0; c = 0;
    while (done !== 1'b1 && c < 4000) begin
      n_cmp++;
      if (addr !== exp_addr[9:0] || wdata !== model[38:0] || req !== 1'b1) begin
        n_err++;
        if (n_err < 20) $display("FAIL stall_write[c=%0d]: addr %0d wdata %h req %b exp addr %0d wdata %h",
                                 c, addr, wdata, req, exp_addr, model[38:0]);
      end
      gnt = (c % 3 == 2);
      if (writes >= 1020) init_req = 0;
      tick();
      if (gnt) begin writes++; exp_addr++; model = lfsr_next(model); end
      c++;
    end
    gnt = 0;
    n_cmp++; if (done !== 1'b1 || writes != 1024 || c != 3072) begin n_err++;
      $display("FAIL stall_total: done %b writes %0d cycles %0d exp 1 1024 3072", done, writes, c); end
  endtask

  task automatic test_key_drop_and_escalate();
    seed = 64'd0; gnt = 1; key_valid = 1; init_req = 1;
    tick();
    init_req = 0;
    n_cmp++; if (wdata !== SeedLow39 || addr !== 10'd0) begin n_err++;
      $display("FAIL zero_seed: wdata %h addr %0d exp %h 0", wdata, addr, SeedLow39); end
    repeat (10) tick();
    n_cmp++; if (addr !== 10'd10) begin n_err++; $display("FAIL key_addr10: got %0d exp 10", addr); end
    key_valid = 0;
    tick(); tick();
    n_cmp++; if ({busy, done, req} !== 3'b000 || addr !== 10'd0) begin n_err++;
      $display("FAIL key_drop: busy/done/req %b addr %0d exp 000 0", {busy, done, req}, addr); end
    key_valid = 1; init_req = 1;
    tick();
    init_req = 0;
    n_cmp++; if (addr !== 10'd0 || wdata !== SeedLow39 || busy !== 1'b1) begin n_err++;
      $display("FAIL restart: addr %0d wdata %h busy %b exp 0 %h 1", addr, wdata, busy, SeedLow39); end
    repeat (500) tick();
    n_cmp++; if (addr !== 10'd500) begin n_err++; $display("FAIL esc_addr500: got %0d exp 500", addr); end
    escalate = 1;
    #1;
    n_cmp++; if (req !== 1'b0 || we !== 1'b0) begin n_err++;
      $display("FAIL esc_comb_drop: req %b we %b exp 0 0", req, we); end
    tick();
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_err++;
      $display("FAIL esc_error: err %b busy %b exp 1 0", err, busy); end
    escalate = 0; init_req = 1;
    repeat (3) tick();
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0 || req !== 1'b0) begin n_err++;
      $display("FAIL esc_sticky: err %b busy %b req %b exp 1 0 0", err, busy, req); end
    rst_n = 0;
    tick();
    rst_n = 1; init_req = 0;
    n_cmp++; if ({req, busy, done, err} !== 4'b0 || addr !== 10'd0 || wdata !== 39'd0) begin n_err++;
      $display("FAIL esc_reset: flags %b addr %0d wdata %h exp 0000 0 0", {req, busy, done, err}, addr, wdata); end
  endtask

  task automatic test_reset_mid();
    seed = 64'd1; gnt = 1; key_valid = 1; init_req = 1;
    tick();
    init_req = 0;
    repeat (700) tick();
    n_cmp++; if (addr !== 10'd700) begin n_err++; $display("FAIL mid_addr700: got %0d exp 700", addr); end
    rst_n = 0;
    tick();
    n_cmp++; if (busy !== 1'b0 || req !== 1'b0 || addr !== 10'd0) begin n_err++;
      $display("FAIL mid_reset: busy %b req %b addr %0d exp 0 0 0", busy, req, addr); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_escalate_last_grant();
    seed = 64'd1; gnt = 1; key_valid = 1; init_req = 1;
    tick();
    init_req = 0;
    repeat (1023) tick();
    n_cmp++; if (addr !== 10'd1023 || req !== 1'b1) begin n_err++;
      $display("FAIL last_addr: addr %0d req %b exp 1023 1", addr, req); end
    escalate = 1;
    tick();
    n_cmp++; if (err !== 1'b1 || done !== 1'b0) begin n_err++;
      $display("FAIL esc_priority: err %b done %b exp 1 0", err, done); end
    escalate = 0; rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_full_grant();
    test_stall();
    test_key_drop_and_escalate();
    test_reset_mid();
    test_escalate_last_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
